// File: rtl/rv_mem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// rv_mem_lsu_pkg
// Shared types for the load/store unit: stage control word, access size and
// write-back select encodings, FSM state constants, a byte-enable helper, and
// the DFF macro used for the unit's registers (it assumes the enclosing module
// has 'clk' and a synchronous active-high 'rst').
// ---------------------------------------------------------------------------
`ifndef RV_DFF_R
`define RV_DFF_R(q_sig, d_sig, rst_val) \
  always_ff @(posedge clk) begin \
    if (rst) q_sig <= (rst_val); \
    else q_sig <= (d_sig); \
  end
`endif

package rv_mem_lsu_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } t_mem_size;

  typedef enum logic [1:0] {
    SEL_PC_PLUS4 = 2'd0,
    SEL_ALU_OUT  = 2'd1,
    SEL_MEM      = 2'd2
  } t_sel_wb;

  typedef struct packed {
    logic      mem_rd;
    logic      mem_wr;
    t_mem_size size;
    logic      is_unsigned;
    t_sel_wb   sel_wb;
  } t_lsu_ctrl;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] lsu_byte_en(input t_mem_size size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      MEM_BYTE: base = 4'b0001;
      MEM_HALF: base = 4'b0011;
      default:  base = 4'b1111;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/rv_mem_lsu_load_align.sv
// ---------------------------------------------------------------------------
// rv_load_align
// Combinational load-data alignment: shifts the addressed lane down to bit 0
// and sign/zero-extends byte and half loads. Word loads pass through.
// Ports:
//   rdata_i       32-bit word returned by data memory
//   offset_i      byte offset of the access within the word
//   size_i        access size
//   is_unsigned_i zero-extend when set, sign-extend otherwise
//   data_o        aligned, extended load value
// ---------------------------------------------------------------------------
module rv_load_align
  import rv_mem_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  t_mem_size   size_i,
  input  logic        is_unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    case (size_i)
      MEM_BYTE: data_o = is_unsigned_i ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      MEM_HALF: data_o = is_unsigned_i ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/rv_mem_lsu.sv
// ---------------------------------------------------------------------------
// rv_mem_lsu
// Memory stage load/store unit. Issues data-memory requests for the Q103H
// instruction, stalls upstream while the request or load response is
// outstanding, and registers the write-back value into Q104H.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ctrl, valid_Q103H     stage control word and instruction valid
//   pc_plus4_Q103H        PC+4 for link write-back
//   alu_out_Q103H         ALU result / effective byte address
//   rs2_data_Q103H        store data
//   dmem_*                data-memory request/response handshake
//   stall_Q103H           hold upstream
//   pre_wb_data_Q104H     registered write-back value
//   valid_Q104H           an instruction retired last cycle
//   misalign_Q104H        retired instruction was a misaligned access
//   timeout_Q104H         retired load gave up waiting for a response
// ---------------------------------------------------------------------------
module rv_mem_lsu
  import rv_mem_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  t_lsu_ctrl         ctrl,
  input  logic              valid_Q103H,
  input  logic [31:0]       pc_plus4_Q103H,
  input  logic [31:0]       alu_out_Q103H,
  input  logic [31:0]       rs2_data_Q103H,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stall_Q103H,
  output logic [31:0]       pre_wb_data_Q104H,
  output logic              valid_Q104H,
  output logic              misalign_Q104H,
  output logic              timeout_Q104H
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Request context captured at issue so a stalled upstream may change freely.
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [1:0]        off_q;
  t_mem_size         size_q;
  logic              uns_q;
  t_sel_wb           sel_q;

  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic              to_q, to_d;

  logic              mem_op, misalign;
  logic [ADDR_W-1:0] live_addr;
  logic [3:0]        live_be;
  logic [31:0]       live_wdata;

  logic              in_idle;
  logic [1:0]        cur_off;
  t_mem_size         cur_size;
  logic              cur_uns;
  t_sel_wb           cur_sel;
  logic [31:0]       load_data, wb_data;

  logic              req_c, stall_c, retire, ret_mis, ret_to, latch_en;

  assign mem_op   = valid_Q103H && (ctrl.mem_rd || ctrl.mem_wr);
  assign misalign = mem_op &&
                    (((ctrl.size == MEM_HALF) && alu_out_Q103H[0]) ||
                     ((ctrl.size == MEM_WORD) && (alu_out_Q103H[1:0] != 2'b00)));

  assign live_addr = {alu_out_Q103H[ADDR_W-1:2], 2'b00};
  assign live_be   = lsu_byte_en(ctrl.size, alu_out_Q103H[1:0]);

  always_comb begin
    case (ctrl.size)
      MEM_BYTE: live_wdata = {4{rs2_data_Q103H[7:0]}};
      MEM_HALF: live_wdata = {2{rs2_data_Q103H[15:0]}};
      default:  live_wdata = rs2_data_Q103H;
    endcase
  end

  // In IDLE the request is issued straight from the live stage inputs; once
  // stalled, everything comes from the captured context.
  assign in_idle  = (state_q == ST_IDLE);
  assign cur_off  = in_idle ? alu_out_Q103H[1:0] : off_q;
  assign cur_size = in_idle ? ctrl.size : size_q;
  assign cur_uns  = in_idle ? ctrl.is_unsigned : uns_q;
  assign cur_sel  = in_idle ? ctrl.sel_wb : sel_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    retire   = 1'b0;
    ret_mis  = 1'b0;
    ret_to   = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_Q103H) begin
          if (mem_op && !misalign) begin
            req_c = 1'b1;
            if (dmem_ready && (ctrl.mem_wr || dmem_rvalid)) begin
              retire = 1'b1;
            end else begin
              stall_c  = 1'b1;
              latch_en = 1'b1;
              cnt_d    = '0;
              state_d  = dmem_ready ? ST_WAIT_RSP : ST_REQ;
            end
          end else begin
            retire  = 1'b1;
            ret_mis = misalign;
          end
        end
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (dmem_ready && (we_q || dmem_rvalid)) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          retire  = 1'b1;
          ret_to  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (dmem_ready) state_d = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (dmem_rvalid) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          retire  = 1'b1;
          ret_to  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset overrides the combinational handshake so nothing leaks out while
  // the state registers are being cleared.
  assign dmem_req    = req_c && !rst;
  assign stall_Q103H = stall_c && !rst;
  assign dmem_we     = req_c && (in_idle ? ctrl.mem_wr : we_q);
  assign dmem_addr   = in_idle ? live_addr : addr_q;
  assign dmem_be     = in_idle ? live_be : be_q;
  assign dmem_wdata  = in_idle ? live_wdata : wdata_q;

  rv_load_align u_load_align (
    .rdata_i       (dmem_rdata),
    .offset_i      (cur_off),
    .size_i        (cur_size),
    .is_unsigned_i (cur_uns),
    .data_o        (load_data)
  );

  // A timed-out load writes back zero regardless of select; a misaligned
  // access has no memory data to offer.
  always_comb begin
    case (cur_sel)
      SEL_PC_PLUS4: wb_data = pc_plus4_Q103H;
      SEL_ALU_OUT:  wb_data = alu_out_Q103H;
      SEL_MEM:      wb_data = ret_mis ? 32'd0 : load_data;
      default:      wb_data = 32'd0;
    endcase
    if (ret_to) wb_data = 32'd0;
  end

  assign valid_d = retire;
  assign data_d  = retire ? wb_data : data_q;
  assign mis_d   = ret_mis;
  assign to_d    = ret_to;

  `RV_DFF_R(state_q, state_d, ST_IDLE)
  `RV_DFF_R(cnt_q,   cnt_d,   '0)
  `RV_DFF_R(data_q,  data_d,  32'd0)
  `RV_DFF_R(valid_q, valid_d, 1'b0)
  `RV_DFF_R(mis_q,   mis_d,   1'b0)
  `RV_DFF_R(to_q,    to_d,    1'b0)

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      off_q   <= 2'd0;
      size_q  <= MEM_BYTE;
      uns_q   <= 1'b0;
      sel_q   <= SEL_PC_PLUS4;
    end else if (latch_en) begin
      addr_q  <= live_addr;
      we_q    <= ctrl.mem_wr;
      be_q    <= live_be;
      wdata_q <= live_wdata;
      off_q   <= alu_out_Q103H[1:0];
      size_q  <= ctrl.size;
      uns_q   <= ctrl.is_unsigned;
      sel_q   <= ctrl.sel_wb;
    end
  end

  assign pre_wb_data_Q104H = data_q;
  assign valid_Q104H       = valid_q;
  assign misalign_Q104H    = mis_q;
  assign timeout_Q104H     = to_q;

endmodule

// File: tb/tb_rv_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_rv_mem_lsu
// Directed bench for the load/store unit: reset state, ALU and PC+4
// write-back, stalled and same-cycle loads with alignment/extension, stores
// with lane replication, misalignment, response timeout, and reset while
// waiting for a response.
// ---------------------------------------------------------------------------
module tb_rv_mem_lsu;
  import rv_mem_lsu_pkg::*;

  logic        clk;
  logic        rst;
  t_lsu_ctrl   ctrl;
  logic        valid_Q103H;
  logic [31:0] pc_plus4_Q103H;
  logic [31:0] alu_out_Q103H;
  logic [31:0] rs2_data_Q103H;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_Q103H;
  logic [31:0] pre_wb_data_Q104H;
  logic        valid_Q104H;
  logic        misalign_Q104H;
  logic        timeout_Q104H;

  int testsRun;
  int testsFailed;
  int cycles;

  rv_mem_lsu #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk               (clk),
    .rst               (rst),
    .ctrl              (ctrl),
    .valid_Q103H       (valid_Q103H),
    .pc_plus4_Q103H    (pc_plus4_Q103H),
    .alu_out_Q103H     (alu_out_Q103H),
    .rs2_data_Q103H    (rs2_data_Q103H),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ready        (dmem_ready),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .stall_Q103H       (stall_Q103H),
    .pre_wb_data_Q104H (pre_wb_data_Q104H),
    .valid_Q104H       (valid_Q104H),
    .misalign_Q104H    (misalign_Q104H),
    .timeout_Q104H     (timeout_Q104H)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input t_mem_size sz, input logic uns, input t_sel_wb sel,
                               input logic [31:0] alu, input logic [31:0] rs2);
    valid_Q103H      = v;
    ctrl.mem_rd      = rd;
    ctrl.mem_wr      = wr;
    ctrl.size        = sz;
    ctrl.is_unsigned = uns;
    ctrl.sel_wb      = sel;
    alu_out_Q103H    = alu;
    rs2_data_Q103H   = rs2;
    #1;
  endtask

  task automatic setMem(input logic rdy, input logic rv, input logic [31:0] rd);
    dmem_ready  = rdy;
    dmem_rvalid = rv;
    dmem_rdata  = rd;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    pc_plus4_Q103H = 32'h0;
    setMem(0, 0, 32'h0);
    applyStimulus(0, 0, 0, MEM_WORD, 0, SEL_ALU_OUT, 32'h0, 32'h0);
    tick;
    tick;
    checkOutput("rst_stall", {31'd0, stall_Q103H}, 32'd0);
    checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, valid_Q104H}, 32'd0);
    checkOutput("rst_data", pre_wb_data_Q104H, 32'd0);
    checkOutput("rst_mis", {31'd0, misalign_Q104H}, 32'd0);
    checkOutput("rst_to", {31'd0, timeout_Q104H}, 32'd0);
    rst = 1'b0;

    // ALU write-back, no memory traffic
    applyStimulus(1, 0, 0, MEM_WORD, 0, SEL_ALU_OUT, 32'h12345678, 32'h0);
    checkOutput("alu_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("alu_stall", {31'd0, stall_Q103H}, 32'd0);
    tick;
    checkOutput("alu_valid", {31'd0, valid_Q104H}, 32'd1);
    checkOutput("alu_data", pre_wb_data_Q104H, 32'h12345678);

    // invalid slot with load control: no request, bubble, data held
    applyStimulus(0, 1, 0, MEM_WORD, 0, SEL_MEM, 32'h100, 32'h0);
    checkOutput("noval_req", {31'd0, dmem_req}, 32'd0);
    tick;
    checkOutput("noval_valid", {31'd0, valid_Q104H}, 32'd0);
    checkOutput("noval_hold", pre_wb_data_Q104H, 32'h12345678);

    // PC+4 write-back
    pc_plus4_Q103H = 32'h404;
    applyStimulus(1, 0, 0, MEM_WORD, 0, SEL_PC_PLUS4, 32'hDEAD0000, 32'h0);
    tick;
    checkOutput("pc4_data", pre_wb_data_Q104H, 32'h404);

    // LB 0x103, memory answers 3 cycles after issue
    applyStimulus(1, 1, 0, MEM_BYTE, 0, SEL_MEM, 32'h103, 32'h0);
    checkOutput("lb_req", {31'd0, dmem_req}, 32'd1);
    checkOutput("lb_we", {31'd0, dmem_we}, 32'd0);
    checkOutput("lb_addr", dmem_addr, 32'h100);
    checkOutput("lb_be", {28'd0, dmem_be}, 32'h8);
    checkOutput("lb_stall0", {31'd0, stall_Q103H}, 32'd1);
    tick;
    applyStimulus(1, 1, 0, MEM_WORD, 1, SEL_ALU_OUT, 32'h0, 32'h0);
    checkOutput("lb_hold_addr", dmem_addr, 32'h100);
    checkOutput("lb_hold_be", {28'd0, dmem_be}, 32'h8);
    checkOutput("lb_stall1", {31'd0, stall_Q103H}, 32'd1);
    checkOutput("lb_bubble", {31'd0, valid_Q104H}, 32'd0);
    tick;
    checkOutput("lb_stall2", {31'd0, stall_Q103H}, 32'd1);
    tick;
    setMem(1, 1, 32'h80123456);
    checkOutput("lb_stall3", {31'd0, stall_Q103H}, 32'd0);
    tick;
    checkOutput("lb_valid", {31'd0, valid_Q104H}, 32'd1);
    checkOutput("lb_data", pre_wb_data_Q104H, 32'hFFFFFF80);

    // same-cycle responses
    applyStimulus(1, 1, 0, MEM_BYTE, 1, SEL_MEM, 32'h103, 32'h0);
    checkOutput("lbu_stall", {31'd0, stall_Q103H}, 32'd0);
    tick;
    checkOutput("lbu_data", pre_wb_data_Q104H, 32'h00000080);
    setMem(1, 1, 32'h80011234);
    applyStimulus(1, 1, 0, MEM_HALF, 0, SEL_MEM, 32'h102, 32'h0);
    tick;
    checkOutput("lh_data", pre_wb_data_Q104H, 32'hFFFF8001);
    applyStimulus(1, 1, 0, MEM_HALF, 1, SEL_MEM, 32'h102, 32'h0);
    tick;
    checkOutput("lhu_data", pre_wb_data_Q104H, 32'h00008001);
    setMem(1, 1, 32'hDEADBEEF);
    applyStimulus(1, 1, 0, MEM_WORD, 0, SEL_MEM, 32'h104, 32'h0);
    checkOutput("lw_be", {28'd0, dmem_be}, 32'hF);
    checkOutput("lw_addr", dmem_addr, 32'h104);
    tick;
    checkOutput("lw_data", pre_wb_data_Q104H, 32'hDEADBEEF);

    // SH 0x102, accepted one cycle late
    setMem(0, 0, 32'h0);
    applyStimulus(1, 0, 1, MEM_HALF, 0, SEL_ALU_OUT, 32'h102, 32'h0000ABCD);
    checkOutput("sh_req", {31'd0, dmem_req}, 32'd1);
    checkOutput("sh_we", {31'd0, dmem_we}, 32'd1);
    checkOutput("sh_be", {28'd0, dmem_be}, 32'hC);
    checkOutput("sh_wdata", dmem_wdata, 32'hABCDABCD);
    checkOutput("sh_addr", dmem_addr, 32'h100);
    checkOutput("sh_stall0", {31'd0, stall_Q103H}, 32'd1);
    tick;
    setMem(1, 0, 32'h0);
    checkOutput("sh_stall1", {31'd0, stall_Q103H}, 32'd0);
    checkOutput("sh_we_req", {31'd0, dmem_we}, 32'd1);
    tick;
    checkOutput("sh_valid", {31'd0, valid_Q104H}, 32'd1);
    checkOutput("sh_data", pre_wb_data_Q104H, 32'h102);

    // SB 0x101, accepted immediately
    applyStimulus(1, 0, 1, MEM_BYTE, 0, SEL_ALU_OUT, 32'h101, 32'h123456EF);
    checkOutput("sb_be", {28'd0, dmem_be}, 32'h2);
    checkOutput("sb_wdata", dmem_wdata, 32'hEFEFEFEF);
    checkOutput("sb_stall", {31'd0, stall_Q103H}, 32'd0);
    tick;
    checkOutput("sb_valid", {31'd0, valid_Q104H}, 32'd1);

    // LW accepted but never answered
    setMem(1, 0, 32'h0);
    applyStimulus(1, 1, 0, MEM_WORD, 0, SEL_MEM, 32'h200, 32'h0);
    cycles = 0;
    while (stall_Q103H && cycles < 40) begin
      cycles++;
      tick;
      if (cycles == 1) setMem(0, 0, 32'h0);
    end
    checkOutput("to_stall_cycles", cycles, 32'd15);
    tick;
    checkOutput("to_flag", {31'd0, timeout_Q104H}, 32'd1);
    checkOutput("to_valid", {31'd0, valid_Q104H}, 32'd1);
    checkOutput("to_data", pre_wb_data_Q104H, 32'd0);
    applyStimulus(0, 0, 0, MEM_WORD, 0, SEL_ALU_OUT, 32'h0, 32'h0);
    setMem(0, 1, 32'hFFFFFFFF);
    checkOutput("late_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("late_stall", {31'd0, stall_Q103H}, 32'd0);
    tick;
    checkOutput("late_valid", {31'd0, valid_Q104H}, 32'd0);
    checkOutput("late_to", {31'd0, timeout_Q104H}, 32'd0);
    setMem(0, 0, 32'h0);

    // misaligned LW after a nonzero result
    applyStimulus(1, 0, 0, MEM_WORD, 0, SEL_ALU_OUT, 32'h55, 32'h0);
    tick;
    checkOutput("pre_mis_data", pre_wb_data_Q104H, 32'h55);
    applyStimulus(1, 1, 0, MEM_WORD, 0, SEL_MEM, 32'h101, 32'h0);
    checkOutput("mis_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("mis_stall", {31'd0, stall_Q103H}, 32'd0);
    tick;
    checkOutput("mis_flag", {31'd0, misalign_Q104H}, 32'd1);
    checkOutput("mis_valid", {31'd0, valid_Q104H}, 32'd1);
    checkOutput("mis_data", pre_wb_data_Q104H, 32'd0);
    applyStimulus(0, 0, 0, MEM_WORD, 0, SEL_ALU_OUT, 32'h0, 32'h0);
    tick;
    checkOutput("mis_clear", {31'd0, misalign_Q104H}, 32'd0);

    // reset while waiting for a load response
    applyStimulus(1, 0, 0, MEM_WORD, 0, SEL_ALU_OUT, 32'h77, 32'h0);
    tick;
    setMem(1, 0, 32'h0);
    applyStimulus(1, 1, 0, MEM_WORD, 0, SEL_MEM, 32'h300, 32'h0);
    tick;
    setMem(0, 0, 32'h0);
    checkOutput("rw_stall", {31'd0, stall_Q103H}, 32'd1);
    tick;
    rst = 1'b1;
    applyStimulus(0, 0, 0, MEM_WORD, 0, SEL_ALU_OUT, 32'h0, 32'h0);
    tick;
    checkOutput("rw_stall_after", {31'd0, stall_Q103H}, 32'd0);
    checkOutput("rw_valid", {31'd0, valid_Q104H}, 32'd0);
    checkOutput("rw_data", pre_wb_data_Q104H, 32'd0);
    rst = 1'b0;
    setMem(0, 1, 32'h11111111);
    checkOutput("rw_late_req", {31'd0, dmem_req}, 32'd0);
    tick;
    checkOutput("rw_late_valid", {31'd0, valid_Q104H}, 32'd0);
    setMem(0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rv_mem_lsu.md
RV_MEM_LSU -- requirements
Module: rv_mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-memory byte-address width (>=3).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for a load response before fault.
REQ-003 SHALL have ports clk  in  1  clock; rst  in  1  reset, synchronous, active-high (one clock, all state on rising edge).
REQ-004 SHALL have ports ctrl  in  t_lsu_ctrl  stage control; valid_Q103H  in  1  instruction valid.
REQ-005 SHALL have ports pc_plus4_Q103H  in  32; alu_out_Q103H  in  32  ALU result/effective address; rs2_data_Q103H  in  32  store data.
REQ-006 SHALL have ports dmem_req  out  1; dmem_we  out  1; dmem_addr  out  ADDR_W  word-aligned; dmem_wdata  out  32; dmem_be  out  4; dmem_ready  in  1  request accepted; dmem_rvalid  in  1; dmem_rdata  in  32.
REQ-007 SHALL have ports stall_Q103H  out  1  hold upstream; pre_wb_data_Q104H  out  32; valid_Q104H  out  1; misalign_Q104H  out  1; timeout_Q104H  out  1.

Function
REQ-008 SHALL decode ctrl fields: mem_rd, mem_wr, size (BYTE/HALF/WORD), is_unsigned, sel_wb (SEL_PC_PLUS4/SEL_ALU_OUT/SEL_MEM).
REQ-009 SHALL flag misalign when valid_Q103H and (mem_rd or mem_wr) and (HALF with addr[0]=1, or WORD with addr[1:0]!=0); misaligned access SHALL issue no dmem_req.
REQ-010 SHALL drive dmem_addr = alu_out[ADDR_W-1:2],2'b00; dmem_be = 0001/0011/1111 for BYTE/HALF/WORD shifted left by addr[1:0].
REQ-011 SHALL drive dmem_wdata = byte replicated x4 (BYTE), half replicated x2 (HALF), rs2 unchanged (WORD).
REQ-012 SHALL implement FSM IDLE, REQ, WAIT_RSP.
REQ-013 IDLE: non-memory valid op -> no stall, result registered next cycle; memory op -> REQ in same cycle (dmem_req asserted combinationally, stall asserted unless dmem_ready and (store, or load with dmem_rvalid same cycle)).
REQ-014 REQ: dmem_req held with stable addr/we/be/wdata until dmem_ready; store + ready -> IDLE, retires; load + ready -> WAIT_RSP (or retire if dmem_rvalid same cycle).
REQ-015 WAIT_RSP: dmem_req=0, stall=1; dmem_rvalid -> retire, IDLE.
REQ-016 SHALL count wait cycles in REQ/WAIT_RSP with counter width clog2(TIMEOUT+1); count reaching TIMEOUT -> retire with timeout_Q104H=1, data 0, IDLE; late rvalid in IDLE SHALL be ignored.
REQ-017 Load data SHALL be dmem_rdata >> (8*addr[1:0]), then sign- or zero-extended from 8/16 bits per is_unsigned; WORD unmodified.
REQ-018 SHALL select write-back: SEL_PC_PLUS4 -> pc_plus4, SEL_ALU_OUT -> alu_out, SEL_MEM -> load data, else 0.
REQ-019 SHALL latch address offset, size, is_unsigned, sel_wb at request issue so upstream changes during stall do not affect result.
REQ-020 On retire, pre_wb_data_Q104H, valid_Q104H=1, misalign/timeout flags SHALL update on next edge; while stalled valid_Q104H SHALL be 0 and pre_wb_data_Q104H SHALL hold.
REQ-021 valid_Q103H=0 SHALL generate no request and valid_Q104H=0 next cycle.

Reset
REQ-022 rst SHALL force FSM IDLE, counter 0, dmem_req 0, stall 0, pre_wb_data_Q104H 0, valid/misalign/timeout 0 at next edge.
REQ-023 rst mid-transaction SHALL abandon it without retiring; a subsequent rvalid SHALL be ignored.

Structure
REQ-024 t_lsu_ctrl, t_mem_size, t_sel_wb (incl. SEL_MEM) SHALL live in pkg.
REQ-025 load align/extend logic SHALL be sub-module rv_load_align (combinational: rdata, offset, size, is_unsigned -> data).
REQ-026 Output registers SHALL use the existing DFF macros.

Verification
REQ-027 ALU op, sel ALU_OUT, alu_out=0x1234_5678 -> pre_wb_data_Q104H=0x12345678 next cycle, no dmem_req.
REQ-028 LB addr 0x103, rdata 0x80xx_xxxx, ready+rvalid after 3 cycles -> stall 3 cycles, data 0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-029 SH addr 0x102, rs2=0xABCD -> dmem_be=1100, wdata=0xABCD_ABCD, we=1.
REQ-030 LW addr 0x101 -> misalign_Q104H=1, no dmem_req, no stall.
REQ-031 LW with ready but no rvalid -> timeout_Q104H=1 after 15 wait cycles, data 0; late rvalid ignored.
REQ-032 rst asserted in WAIT_RSP -> IDLE, stall 0 next cycle, no retire.
